// File: rtl/asip_pkg.sv
// Shared types and widths for the 16-bit RSA ASIP pipeline.
package asip_pkg;
  localparam int ARQ              = 16;
  localparam int MEMORY_ADDR_SIZE = 13;
  localparam int REG_ADDR_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                  valid;
    logic [ARQ-1:0]        alu_result;
    logic [ARQ-1:0]        store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_wr;
    logic                  mem_rd;
    logic                  mem_wr;
  } exe_mem_bus_t;

  typedef struct packed {
    logic                  valid;
    logic [ARQ-1:0]        result;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_wr;
  } mem_wb_bus_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait counter for an outstanding data-memory request; flags the cycle that uses up the budget.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_clr) r_cnt <= '0;
    else if (i_en)       r_cnt <= r_cnt + CW'(1);
  end

  // Expires during the TIMEOUT-th waiting cycle, so req is held exactly TIMEOUT cycles.
  assign o_expired = i_en && (r_cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: pass-through of ALU results, load/store over a req/ack handshake, stall of EXE.
module mem_access_stage
  import asip_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_exe_valid,
  input  logic [ARQ-1:0]              i_exe_alu_result,
  input  logic [ARQ-1:0]              i_exe_store_data,
  input  logic [REG_ADDR_W-1:0]       i_exe_rd,
  input  logic                        i_exe_reg_wr,
  input  logic                        i_exe_mem_rd,
  input  logic                        i_exe_mem_wr,
  output logic                        o_mem_stall,
  output logic                        o_dmem_req,
  output logic                        o_dmem_we,
  output logic [MEMORY_ADDR_SIZE-1:0] o_dmem_addr,
  output logic [ARQ-1:0]              o_dmem_wdata,
  input  logic [ARQ-1:0]              i_dmem_rdata,
  input  logic                        i_dmem_ack,
  output logic                        o_wb_valid,
  output logic [ARQ-1:0]              o_wb_result,
  output logic [REG_ADDR_W-1:0]       o_wb_rd,
  output logic                        o_wb_reg_wr,
  output logic                        o_mem_fault
);
  exe_mem_bus_t w_exe;
  logic         w_mem_op;
  logic         w_range_err;
  logic         w_expired;

  mem_state_t                  r_state;
  logic                        r_req;
  logic                        r_we;
  logic [MEMORY_ADDR_SIZE-1:0] r_addr;
  logic [ARQ-1:0]              r_wdata;
  logic [ARQ-1:0]              r_alu;
  logic [ARQ-1:0]              r_result;
  logic [REG_ADDR_W-1:0]       r_rd;
  logic                        r_reg_wr;
  logic                        r_op_fault;
  logic                        r_fault;
  mem_wb_bus_t                 r_wb;

  assign w_exe = '{valid: i_exe_valid, alu_result: i_exe_alu_result,
                   store_data: i_exe_store_data, rd: i_exe_rd, reg_wr: i_exe_reg_wr,
                   mem_rd: i_exe_mem_rd, mem_wr: i_exe_mem_wr};

  assign w_mem_op    = w_exe.mem_rd | w_exe.mem_wr;
  assign w_range_err = |w_exe.alu_result[ARQ-1:MEMORY_ADDR_SIZE];

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (r_state == IDLE),
    .i_en      ((r_state == REQ) && !i_dmem_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_alu      <= '0;
      r_result   <= '0;
      r_rd       <= '0;
      r_reg_wr   <= 1'b0;
      r_op_fault <= 1'b0;
      r_fault    <= 1'b0;
      r_wb       <= '0;
    end else begin
      r_wb.valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_exe.valid && !w_mem_op) begin
            r_wb <= '{valid: 1'b1, result: w_exe.alu_result, rd: w_exe.rd, reg_wr: w_exe.reg_wr};
          end else if (w_exe.valid) begin
            r_we     <= w_exe.mem_wr;
            r_addr   <= w_exe.alu_result[MEMORY_ADDR_SIZE-1:0];
            r_wdata  <= w_exe.store_data;
            r_alu    <= w_exe.alu_result;
            r_rd     <= w_exe.rd;
            r_reg_wr <= w_exe.reg_wr;
            r_result <= '0;
            // Out-of-range addresses never reach memory; the op retires faulted.
            if (w_range_err) begin
              r_fault    <= 1'b1;
              r_op_fault <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_op_fault <= 1'b0;
              r_req      <= 1'b1;
              r_state    <= REQ;
            end
          end
        end
        REQ: begin
          if (i_dmem_ack) begin
            r_req    <= 1'b0;
            r_result <= r_we ? r_alu : i_dmem_rdata;
            r_state  <= DONE;
          end else if (w_expired) begin
            r_req      <= 1'b0;
            r_fault    <= 1'b1;
            r_op_fault <= 1'b1;
            r_result   <= '0;
            r_state    <= DONE;
          end
        end
        DONE: begin
          r_wb    <= '{valid: 1'b1, result: r_result, rd: r_rd, reg_wr: r_reg_wr & ~r_op_fault};
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mem_stall  = (r_state != IDLE);
  assign o_dmem_req   = r_req;
  assign o_dmem_we    = r_we;
  assign o_dmem_addr  = r_addr;
  assign o_dmem_wdata = r_wdata;
  assign o_wb_valid   = r_wb.valid;
  assign o_wb_result  = r_wb.result;
  assign o_wb_rd      = r_wb.rd;
  assign o_wb_reg_wr  = r_wb.reg_wr;
  assign o_mem_fault  = r_fault;
endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a transaction planner builds per-cycle expectations, checked every cycle.
module tb_mem_access_stage;
  localparam int TO = 15;
  localparam int N  = 96;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, exe_valid, exe_reg_wr, exe_mem_rd, exe_mem_wr, dmem_ack;
  logic [15:0] exe_alu_result, exe_store_data, dmem_rdata;
  logic [3:0]  exe_rd;
  logic        mem_stall, dmem_req, dmem_we, wb_valid, wb_reg_wr, mem_fault;
  logic [12:0] dmem_addr;
  logic [15:0] dmem_wdata, wb_result;
  logic [3:0]  wb_rd;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_exe_valid(exe_valid), .i_exe_alu_result(exe_alu_result),
    .i_exe_store_data(exe_store_data), .i_exe_rd(exe_rd), .i_exe_reg_wr(exe_reg_wr),
    .i_exe_mem_rd(exe_mem_rd), .i_exe_mem_wr(exe_mem_wr), .o_mem_stall(mem_stall),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .i_dmem_rdata(dmem_rdata), .i_dmem_ack(dmem_ack),
    .o_wb_valid(wb_valid), .o_wb_result(wb_result), .o_wb_rd(wb_rd),
    .o_wb_reg_wr(wb_reg_wr), .o_mem_fault(mem_fault)
  );

  // per-cycle stimulus
  logic        in_rst[N], in_valid[N], in_rw[N], in_mrd[N], in_mwr[N], in_ack[N];
  logic [15:0] in_alu[N], in_sd[N], in_rdata[N];
  logic [3:0]  in_rd[N];
  // per-cycle expectations
  logic        e_req[N], e_stall[N], e_wbv[N], e_fault[N], e_we[N], e_rst0[N], wb_set[N], e_rw[N];
  logic [12:0] e_addr[N];
  logic [15:0] e_wdata[N], e_res[N];
  logic [3:0]  e_rd[N];
  // observed
  logic        a_req[N], a_stall[N], a_fault[N], a_we[N];
  logic [12:0] a_addr[N];
  logic [15:0] obs_res[$];
  logic [3:0]  obs_rd[$];
  logic        obs_rw[$];

  logic [15:0] mem[8192];
  logic [15:0] want_res[12];
  logic [3:0]  want_rd[12];
  logic        want_rw[12];
  int t, last_acc, cyc, checks, errors;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic set_wb(int c, logic [15:0] r, logic [3:0] rd, logic rw);
    if (c < N) begin
      e_wbv[c] = 1'b1; wb_set[c] = 1'b1; e_res[c] = r; e_rd[c] = rd; e_rw[c] = rw;
    end
  endtask

  task automatic set_fault(int f);
    for (int x = f; x < N; x++) e_fault[x] = 1'b1;
  endtask

  // Plans one instruction: presented after 'gap' idle cycles (gap 0 = held by EXE while stalled).
  // d = cycles from first req cycle to ack, -1 = memory never answers.
  task automatic plan_op(int gap, logic [15:0] alu, logic [15:0] sd, logic [3:0] rd,
                         logic rw, logic mrd, logic mwr, int d);
    int c, k, st;
    bit okack;
    logic [12:0] a;
    logic [15:0] res;
    c  = t + gap;
    st = (gap == 0) ? last_acc + 1 : c;
    for (int x = st; x <= c; x++) begin
      in_valid[x] = 1'b1; in_alu[x] = alu; in_sd[x] = sd; in_rd[x] = rd;
      in_rw[x] = rw; in_mrd[x] = mrd; in_mwr[x] = mwr;
    end
    if (!(mrd || mwr)) begin
      set_wb(c + 1, alu, rd, rw);
      t = c + 1;
    end else if (alu >= 16'h2000) begin
      e_stall[c + 1] = 1'b1;
      set_fault(c + 1);
      set_wb(c + 2, 16'h0000, rd, 1'b0);
      t = c + 2;
    end else begin
      a     = alu[12:0];
      okack = (d >= 0) && (d < TO);
      k     = okack ? d + 1 : TO;
      for (int x = 1; x <= k; x++) begin
        e_req[c + x] = 1'b1; e_we[c + x] = mwr; e_addr[c + x] = a;
        e_wdata[c + x] = sd; e_stall[c + x] = 1'b1;
      end
      e_stall[c + k + 1] = 1'b1;
      res = !okack ? 16'h0000 : (mwr ? alu : mem[a]);
      if (okack) begin
        in_ack[c + k]   = 1'b1;
        in_rdata[c + k] = mwr ? 16'h5A5A : mem[a];
      end
      if (okack && mwr) mem[a] = sd;
      if (!okack) set_fault(c + k + 1);
      set_wb(c + k + 2, res, rd, rw & okack);
      t = c + k + 2;
    end
    last_acc = c;
  endtask

  task automatic plan_reset(int r, int len);
    for (int x = r; x < r + len; x++) begin in_rst[x] = 1'b0; in_valid[x] = 1'b0; end
    for (int x = r + 1; x < N; x++) begin
      e_req[x] = 1'b0; e_stall[x] = 1'b0; e_wbv[x] = 1'b0; e_fault[x] = 1'b0; wb_set[x] = 1'b0;
    end
    for (int x = r + 1; x <= r + len; x++) begin
      e_rst0[x] = 1'b1; wb_set[x] = 1'b1; e_res[x] = '0; e_rd[x] = '0; e_rw[x] = 1'b0;
    end
    t = r + len;
    last_acc = t - 1;
  endtask

  task automatic apply(int c);
    rst = in_rst[c]; exe_valid = in_valid[c]; exe_alu_result = in_alu[c];
    exe_store_data = in_sd[c]; exe_rd = in_rd[c]; exe_reg_wr = in_rw[c];
    exe_mem_rd = in_mrd[c]; exe_mem_wr = in_mwr[c]; dmem_ack = in_ack[c]; dmem_rdata = in_rdata[c];
  endtask

  task automatic compare(int c);
    chk("mem_stall", 32'(mem_stall), 32'(e_stall[c]));
    chk("dmem_req", 32'(dmem_req), 32'(e_req[c]));
    chk("wb_valid", 32'(wb_valid), 32'(e_wbv[c]));
    chk("mem_fault", 32'(mem_fault), 32'(e_fault[c]));
    chk("wb_result", 32'(wb_result), 32'(e_res[c]));
    chk("wb_rd", 32'(wb_rd), 32'(e_rd[c]));
    chk("wb_reg_wr", 32'(wb_reg_wr), 32'(e_rw[c]));
    if (e_req[c]) begin
      chk("dmem_we", 32'(dmem_we), 32'(e_we[c]));
      chk("dmem_addr", 32'(dmem_addr), 32'(e_addr[c]));
      if (e_we[c]) chk("dmem_wdata", 32'(dmem_wdata), 32'(e_wdata[c]));
    end
    if (e_rst0[c]) begin
      chk("rst_we", 32'(dmem_we), 32'd0);
      chk("rst_addr", 32'(dmem_addr), 32'd0);
      chk("rst_wdata", 32'(dmem_wdata), 32'd0);
    end
    a_req[c] = dmem_req; a_stall[c] = mem_stall; a_fault[c] = mem_fault;
    a_we[c] = dmem_we; a_addr[c] = dmem_addr;
    if (wb_valid === 1'b1) begin
      obs_res.push_back(wb_result); obs_rd.push_back(wb_rd); obs_rw.push_back(wb_reg_wr);
    end
  endtask

  initial begin
    int s, n;
    checks = 0; errors = 0; cyc = 0;
    for (int x = 0; x < N; x++) begin
      in_rst[x] = 1'b1; in_valid[x] = 1'b0; in_rw[x] = 1'b0; in_mrd[x] = 1'b0; in_mwr[x] = 1'b0;
      in_ack[x] = 1'b0; in_alu[x] = '0; in_sd[x] = '0; in_rdata[x] = '0; in_rd[x] = '0;
      e_req[x] = 1'b0; e_stall[x] = 1'b0; e_wbv[x] = 1'b0; e_fault[x] = 1'b0; e_we[x] = 1'b0;
      e_rst0[x] = 1'b0; wb_set[x] = 1'b0; e_rw[x] = 1'b0; e_addr[x] = '0; e_wdata[x] = '0;
      e_res[x] = '0; e_rd[x] = '0;
    end
    for (int x = 0; x < 8192; x++) mem[x] = 16'h0000;
    mem[13'h0040] = 16'hBEEF;

    t = 0; last_acc = -1;
    plan_reset(0, 2);
    plan_op(0, 16'd17,   16'h0000, 4'd3,  1'b1, 1'b0, 1'b0, 0);   // pass-through
    plan_op(1, 16'h0040, 16'h0000, 4'd5,  1'b1, 1'b1, 1'b0, 2);   // load, ack 2 cycles after req
    plan_op(1, 16'h1FFF, 16'h1234, 4'd0,  1'b0, 1'b0, 1'b1, 0);   // store
    plan_op(0, 16'h1FFF, 16'h0000, 4'd6,  1'b1, 1'b1, 1'b0, 0);   // load back-to-back
    plan_op(0, 16'h0005, 16'hA5A5, 4'd2,  1'b1, 1'b1, 1'b1, 1);   // rd+wr -> store
    plan_op(2, 16'h0005, 16'h0000, 4'd4,  1'b1, 1'b1, 1'b0, 3);
    plan_op(1, 16'hFFFF, 16'h0000, 4'd15, 1'b0, 1'b0, 1'b0, 0);
    plan_op(1, 16'h2000, 16'h0000, 4'd9,  1'b1, 1'b1, 1'b0, 0);   // range fault
    plan_reset(34, 2);
    plan_op(0, 16'h0100, 16'h0000, 4'd7,  1'b1, 1'b1, 1'b0, -1);  // timeout
    plan_op(0, 16'h0042, 16'h0000, 4'd1,  1'b1, 1'b0, 1'b0, 0);
    plan_reset(55, 2);
    plan_op(0, 16'h0040, 16'h0000, 4'd8,  1'b1, 1'b1, 1'b0, 14);  // ack in 15th req cycle
    plan_op(1, 16'h0041, 16'h0000, 4'd10, 1'b1, 1'b1, 1'b0, -1);
    plan_reset(78, 1);                                            // reset while in REQ
    in_ack[80] = 1'b1; in_rdata[80] = 16'hDEAD;                   // late ack
    plan_op(3, 16'h0077, 16'h0000, 4'd11, 1'b1, 1'b0, 1'b0, 0);
    // wb fields hold between pulses
    for (int x = 2; x < N; x++)
      if (!wb_set[x]) begin e_res[x] = e_res[x-1]; e_rd[x] = e_rd[x-1]; e_rw[x] = e_rw[x-1]; end

    want_res = '{16'd17, 16'hBEEF, 16'h1FFF, 16'h1234, 16'h0005, 16'hA5A5,
                 16'hFFFF, 16'h0000, 16'h0000, 16'h0042, 16'hBEEF, 16'h0077};
    want_rd  = '{4'd3, 4'd5, 4'd0, 4'd6, 4'd2, 4'd4, 4'd15, 4'd9, 4'd7, 4'd1, 4'd8, 4'd11};
    want_rw  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    apply(0);
    fork
      for (int c = 1; c < N; c++) begin @(posedge clk); #1; cyc = c; apply(c); end
      for (int c = 1; c < N; c++) begin @(negedge clk); compare(c); end
    join

    // hand-computed pins
    chk("load_stall_before", 32'(a_stall[4]), 32'd0);
    s = 0; for (int x = 5; x <= 8; x++) s += int'(a_stall[x]);
    chk("load_stall_cycles", 32'(s), 32'd4);
    chk("load_stall_after", 32'(a_stall[9]), 32'd0);
    chk("load_addr", 32'(a_addr[5]), 32'h0040);
    chk("load_we", 32'(a_we[5]), 32'd0);
    chk("range_fault_pre", 32'(a_fault[31]), 32'd0);
    chk("range_fault_set", 32'(a_fault[32]), 32'd1);
    s = 0; for (int x = 31; x <= 33; x++) s += int'(a_req[x]);
    chk("range_no_req", 32'(s), 32'd0);
    s = 0; for (int x = 37; x <= 51; x++) s += int'(a_req[x]);
    chk("timeout_req_cycles", 32'(s), 32'd15);
    chk("timeout_req_drop", 32'(a_req[52]), 32'd0);
    chk("timeout_fault_pre", 32'(a_fault[51]), 32'd0);
    chk("timeout_fault_set", 32'(a_fault[52]), 32'd1);
    chk("ack15_no_fault", 32'(a_fault[75]), 32'd0);
    chk("rst_mid_req", 32'(a_req[79]), 32'd0);
    chk("rst_mid_stall", 32'(a_stall[79]), 32'd0);
    chk("late_ack_stall", 32'(a_stall[81]), 32'd0);
    chk("wb_count", 32'(obs_res.size()), 32'd12);
    n = (obs_res.size() < 12) ? obs_res.size() : 12;
    for (int i = 0; i < n; i++) begin
      chk("wb_seq_result", 32'(obs_res[i]), 32'(want_res[i]));
      chk("wb_seq_rd", 32'(obs_rd[i]), 32'(want_rd[i]));
      chk("wb_seq_reg_wr", 32'(obs_rw[i]), 32'(want_rw[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
